// File: rtl/tick_divider_if.sv
// Control and status bundle for tick_divider.
// Carries enable, clear and divisor load in; per-channel tick pulse and square wave out.
interface tick_divider_if #(
    parameter int NCH  = 4,
    parameter int DIVW = 26
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic            en;
    logic            clr;
    logic            ld;
    logic [CHW-1:0]  ld_ch;
    logic [DIVW-1:0] ld_div;
    logic [NCH-1:0]  tick;
    logic [NCH-1:0]  sq;

    modport master (output en, clr, ld, ld_ch, ld_div, input tick, sq);
    modport slave  (input en, clr, ld, ld_ch, ld_div, output tick, sq);
endinterface

// File: rtl/tick_divider.sv
// Multi-channel programmable tick divider: per-channel divisor, one-cycle tick and square wave.
// Latency: tick/sq are registered and appear one cycle after the terminal-count advance.
// Backpressure: none; en low pauses every channel without losing phase.
module tick_divider #(
    parameter int NCH     = 4,
    parameter int DIVW    = 26,
    parameter int DEF_DIV = 25_000_000,
    parameter int CASCADE = 0
) (
    input  logic          clk,
    input  logic          rst,
    tick_divider_if.slave bus
);
    localparam int              CHW     = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [DIVW-1:0] RST_DIV = DIVW'(DEF_DIV);
    localparam logic [DIVW-1:0] ONE     = DIVW'(1);

    logic [DIVW-1:0] div_q [NCH];
    logic [DIVW-1:0] cnt_q [NCH];
    logic [NCH-1:0]  tick_q;
    logic [NCH-1:0]  sq_q;
    logic [NCH-1:0]  term;
    logic [NCH-1:0]  adv;
    logic [NCH-1:0]  ld_hit;
    logic            chain;

    always_comb begin
        chain  = bus.en;
        term   = '0;
        adv    = '0;
        ld_hit = '0;
        for (int i = 0; i < NCH; i++) begin
            // div==0 acts as 1; >= lets a count stranded above the divisor wrap instead of overflowing
            term[i]   = (div_q[i] == '0) ? 1'b1 : (cnt_q[i] >= (div_q[i] - ONE));
            adv[i]    = (CASCADE != 0) ? chain : bus.en;
            chain     = chain & term[i];
            // an out-of-range ld_ch matches no channel, so the load is dropped
            ld_hit[i] = bus.ld && (bus.ld_ch == CHW'(i));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NCH; i++) begin
                div_q[i]  <= RST_DIV;
                cnt_q[i]  <= '0;
                tick_q[i] <= 1'b0;
                sq_q[i]   <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (ld_hit[i])
                    div_q[i] <= bus.ld_div;

                if (bus.clr || ld_hit[i]) begin
                    cnt_q[i]  <= '0;
                    tick_q[i] <= 1'b0;
                    if (bus.clr)
                        sq_q[i] <= 1'b0;
                end else if (adv[i]) begin
                    if (term[i]) begin
                        cnt_q[i]  <= '0;
                        tick_q[i] <= 1'b1;
                        sq_q[i]   <= ~sq_q[i];
                    end else begin
                        cnt_q[i]  <= cnt_q[i] + ONE;
                        tick_q[i] <= 1'b0;
                    end
                end else begin
                    tick_q[i] <= 1'b0;
                end
            end
        end
    end

    assign bus.tick = tick_q;
    assign bus.sq   = sq_q;
endmodule

// File: tb/tb_tick_divider.sv
// Bench for tick_divider: a free-running and a cascaded instance share stimulus and are
// compared every cycle against a behavioural model, plus directed period/latency checks.
module tb_tick_divider;
    localparam int NCH     = 3;
    localparam int DIVW    = 8;
    localparam int DEF_DIV = 5;
    localparam int CHW     = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            en = 1'b0, clr = 1'b0, ld = 1'b0;
    logic [CHW-1:0]  ld_ch = '0;
    logic [DIVW-1:0] ld_div = '0;
    int              total = 0, bad = 0;

    tick_divider_if #(.NCH(NCH), .DIVW(DIVW)) ifa ();
    tick_divider_if #(.NCH(NCH), .DIVW(DIVW)) ifc ();

    assign ifa.en = en;  assign ifa.clr = clr;  assign ifa.ld = ld;
    assign ifa.ld_ch = ld_ch;  assign ifa.ld_div = ld_div;
    assign ifc.en = en;  assign ifc.clr = clr;  assign ifc.ld = ld;
    assign ifc.ld_ch = ld_ch;  assign ifc.ld_div = ld_div;

    tick_divider #(.NCH(NCH), .DIVW(DIVW), .DEF_DIV(DEF_DIV), .CASCADE(0)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa));
    tick_divider #(.NCH(NCH), .DIVW(DIVW), .DEF_DIV(DEF_DIV), .CASCADE(1)) dut_c (
        .clk(clk), .rst(rst), .bus(ifc));

    always #5 clk = ~clk;

    // Model state; first index 0 = free-running instance, 1 = cascaded instance.
    int m_div [2][NCH];
    int m_cnt [2][NCH];
    bit m_tick[2][NCH];
    bit m_sq  [2][NCH];

    wire [4*NCH-1:0] observed = {ifc.sq, ifc.tick, ifa.sq, ifa.tick};

    function automatic void model_reset();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < NCH; i++) begin
                m_div[k][i] = DEF_DIV; m_cnt[k][i] = 0; m_tick[k][i] = 0; m_sq[k][i] = 0;
            end
    endfunction

    function automatic void model_step();
        for (int k = 0; k < 2; k++) begin
            bit at_end[NCH];
            bit moves[NCH];
            for (int i = 0; i < NCH; i++) begin
                int d = (m_div[k][i] < 1) ? 1 : m_div[k][i];
                at_end[i] = (m_cnt[k][i] >= d - 1);
            end
            // cascaded channel i moves only when every lower channel is on its last count
            for (int i = 0; i < NCH; i++) begin
                moves[i] = en;
                if (k == 1)
                    for (int j = 0; j < i; j++) moves[i] = moves[i] & at_end[j];
            end
            for (int i = 0; i < NCH; i++) begin
                bit hit = ld && (int'(ld_ch) == i);
                if (hit) m_div[k][i] = int'(ld_div);
                if (clr || hit) begin
                    m_cnt[k][i] = 0; m_tick[k][i] = 0;
                    if (clr) m_sq[k][i] = 0;
                end else if (moves[i] && at_end[i]) begin
                    m_cnt[k][i] = 0; m_tick[k][i] = 1; m_sq[k][i] = !m_sq[k][i];
                end else if (moves[i]) begin
                    m_cnt[k][i] = m_cnt[k][i] + 1; m_tick[k][i] = 0;
                end else begin
                    m_tick[k][i] = 0;
                end
            end
        end
    endfunction

    function automatic logic [4*NCH-1:0] expected();
        logic [NCH-1:0] t0, s0, t1, s1;
        for (int i = 0; i < NCH; i++) begin
            t0[i] = m_tick[0][i]; s0[i] = m_sq[0][i];
            t1[i] = m_tick[1][i]; s1[i] = m_sq[1][i];
        end
        return {s1, t1, s0, t0};
    endfunction

    task automatic step();
        if (rst) model_step(); else model_reset();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        en = 0; clr = 0; ld = 0;
        #2 rst = 1'b0; #1;
        model_reset();
        total++; if (observed !== '0) begin bad++; $display("FAIL reset_async got=%h want=0", observed); end
        repeat (2) step();
        total++; if (observed !== '0) begin bad++; $display("FAIL reset_hold got=%h want=0", observed); end
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            total++; if (observed !== expected()) begin bad++; $display("FAIL idle_after_reset k=%0d got=%h want=%h", k, observed, expected()); end
        end
    endtask

    task automatic test_first_tick();
        en = 1;
        for (int k = 1; k <= 12; k++) begin
            step();
            total++; if (ifa.tick[0] !== (k % 5 == 0)) begin bad++; $display("FAIL first_tick k=%0d got=%b want=%b", k, ifa.tick[0], (k % 5 == 0)); end
            total++; if (ifa.sq[0] !== ((k / 5) % 2 == 1)) begin bad++; $display("FAIL first_sq k=%0d got=%b want=%b", k, ifa.sq[0], ((k / 5) % 2 == 1)); end
            total++; if (observed !== expected()) begin bad++; $display("FAIL first_model k=%0d got=%h want=%h", k, observed, expected()); end
        end
    endtask

    task automatic test_period();
        bit s0;
        en = 1; ld = 1; ld_ch = 0; ld_div = 4;
        step();
        ld = 0;
        s0 = m_sq[0][0];
        total++; if (ifa.tick[0] !== 1'b0) begin bad++; $display("FAIL ld_clears_tick got=%b want=0", ifa.tick[0]); end
        for (int k = 1; k <= 16; k++) begin
            step();
            total++; if (ifa.tick[0] !== (k % 4 == 0)) begin bad++; $display("FAIL period_tick k=%0d got=%b want=%b", k, ifa.tick[0], (k % 4 == 0)); end
            total++; if (ifa.sq[0] !== (s0 ^ ((k / 4) % 2 == 1))) begin bad++; $display("FAIL period_sq k=%0d got=%b want=%b", k, ifa.sq[0], (s0 ^ ((k / 4) % 2 == 1))); end
            total++; if (observed !== expected()) begin bad++; $display("FAIL period_model k=%0d got=%h want=%h", k, observed, expected()); end
        end
    endtask

    task automatic test_pause();
        en = 1; ld = 1; ld_ch = 0; ld_div = 4;
        step();
        ld = 0;
        for (int k = 1; k <= 10; k++) begin
            en = !(k >= 3 && k <= 5);
            step();
            total++; if (ifa.tick[0] !== (k == 7)) begin bad++; $display("FAIL pause_tick k=%0d got=%b want=%b", k, ifa.tick[0], (k == 7)); end
            total++; if (observed !== expected()) begin bad++; $display("FAIL pause_model k=%0d got=%h want=%h", k, observed, expected()); end
        end
    endtask

    task automatic test_cascade();
        logic [1:0] want;
        en = 0; clr = 1; ld = 1; ld_ch = 0; ld_div = 3;
        step();
        total++; if ({ifc.sq, ifa.sq} !== '0) begin bad++; $display("FAIL clr_sq got=%h want=0", {ifc.sq, ifa.sq}); end
        clr = 0; ld_ch = 1; ld_div = 2;
        step();
        ld = 0; en = 1;
        for (int k = 1; k <= 13; k++) begin
            step();
            want = {1'(k % 6 == 0), 1'(k % 3 == 0)};
            total++; if (ifc.tick[1:0] !== want) begin bad++; $display("FAIL cascade_tick k=%0d got=%b want=%b", k, ifc.tick[1:0], want); end
            total++; if (observed !== expected()) begin bad++; $display("FAIL cascade_model k=%0d got=%h want=%h", k, observed, expected()); end
        end
    endtask

    task automatic test_div01();
        bit prev;
        en = 1;
        for (int v = 0; v <= 1; v++) begin
            ld = 1; ld_ch = 2; ld_div = DIVW'(v);
            step();
            ld = 0;
            for (int k = 1; k <= 4; k++) begin
                prev = m_sq[0][2];
                step();
                total++; if (ifa.tick[2] !== 1'b1) begin bad++; $display("FAIL div%0d_tick k=%0d got=%b want=1", v, k, ifa.tick[2]); end
                total++; if (ifa.sq[2] !== !prev) begin bad++; $display("FAIL div%0d_sq k=%0d got=%b want=%b", v, k, ifa.sq[2], !prev); end
            end
        end
        ld = 1; ld_ch = 3; ld_div = 7;
        step();
        ld = 0;
        total++; if (ifa.tick[2] !== 1'b1) begin bad++; $display("FAIL ignore_ld_tick got=%b want=1", ifa.tick[2]); end
        total++; if (observed !== expected()) begin bad++; $display("FAIL ignore_ld_model got=%h want=%h", observed, expected()); end
    endtask

    task automatic test_reload();
        en = 1; ld = 1; ld_ch = 0; ld_div = 10;
        step();
        ld = 0;
        repeat (7) step();
        ld = 1; ld_div = 5;
        step();
        ld = 0;
        total++; if (ifa.tick[0] !== 1'b0) begin bad++; $display("FAIL reload_tick0 got=%b want=0", ifa.tick[0]); end
        for (int k = 1; k <= 6; k++) begin
            step();
            total++; if (ifa.tick[0] !== (k == 5)) begin bad++; $display("FAIL reload_tick k=%0d got=%b want=%b", k, ifa.tick[0], (k == 5)); end
        end
        clr = 1; ld = 1; ld_ch = 1; ld_div = 3;
        step();
        clr = 0; ld = 0;
        total++; if ({ifc.sq, ifa.sq} !== '0) begin bad++; $display("FAIL clr_ld_sq got=%h want=0", {ifc.sq, ifa.sq}); end
        for (int k = 1; k <= 4; k++) begin
            step();
            total++; if (ifa.tick[1] !== (k == 3)) begin bad++; $display("FAIL clr_ld_tick1 k=%0d got=%b want=%b", k, ifa.tick[1], (k == 3)); end
            total++; if (observed !== expected()) begin bad++; $display("FAIL clr_ld_model k=%0d got=%h want=%h", k, observed, expected()); end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            en     = ($urandom_range(0, 3) != 0);
            clr    = ($urandom_range(0, 31) == 0);
            ld     = ($urandom_range(0, 7) == 0);
            ld_ch  = CHW'($urandom_range(0, 3));
            ld_div = DIVW'($urandom_range(0, 7));
            step();
            total++; if (observed !== expected()) begin bad++; $display("FAIL random n=%0d got=%h want=%h", n, observed, expected()); end
        end
        clr = 0; ld = 0;
    endtask

    task automatic test_reset_mid();
        en = 1; ld = 1; ld_ch = 0; ld_div = 3;
        step();
        ld = 0;
        repeat (2) step();
        rst = 1'b0; #1;
        model_reset();
        total++; if (observed !== '0) begin bad++; $display("FAIL mid_reset_async got=%h want=0", observed); end
        repeat (2) step();
        total++; if (observed !== '0) begin bad++; $display("FAIL mid_reset_hold got=%h want=0", observed); end
        rst = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            step();
            total++; if (ifa.tick[0] !== (k % 5 == 0)) begin bad++; $display("FAIL mid_reset_tick k=%0d got=%b want=%b", k, ifa.tick[0], (k % 5 == 0)); end
            total++; if (observed !== expected()) begin bad++; $display("FAIL mid_reset_model k=%0d got=%h want=%h", k, observed, expected()); end
        end
    endtask

    initial begin
        test_reset();
        test_first_tick();
        test_period();
        test_pause();
        test_cascade();
        test_div01();
        test_reload();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tick_divider.md
TICK_DIVIDER -- requirements
Module: tick_divider

Interface
REQ-001 The block SHALL have parameter NCH, default 4, giving the number of independent divider channels (1..16).
REQ-002 The block SHALL have parameter DIVW, default 26, giving the divisor and counter width in bits.
REQ-003 The block SHALL have parameter DEF_DIV, default 25_000_000, giving the reset divisor of every channel (1 Hz square wave at 50 MHz).
REQ-004 The block SHALL have parameter CASCADE, default 0; when 0 every channel advances on enabled clk cycles, when 1 channel i>0 advances only on channel i-1 terminal counts.
REQ-005 The block SHALL have input clk, 1 bit, the system clock, with all state updated on the rising edge.
REQ-006 The block SHALL have input rst, 1 bit, an asynchronous active-low reset.
REQ-007 The block SHALL have input en, 1 bit; 1 = counting, 0 = pause.
REQ-008 The block SHALL have input clr, 1 bit, a synchronous restart of all channels.
REQ-009 The block SHALL have input ld, 1 bit, a one-cycle divisor load strobe.
REQ-010 The block SHALL have input ld_ch, width max(1,clog2(NCH)), selecting the channel to load.
REQ-011 The block SHALL have input ld_div, DIVW bits, carrying the new divisor value.
REQ-012 The block SHALL have output tick, NCH bits, registered one-cycle pulse per channel on terminal count.
REQ-013 The block SHALL have output sq, NCH bits, registered square wave per channel that toggles on each tick.

Function
REQ-014 Each channel i SHALL hold registers div[i] (DIVW), cnt[i] (DIVW), tick[i] and sq[i].
REQ-015 The effective divisor d[i] SHALL be max(div[i],1); div=0 SHALL behave exactly as div=1.
REQ-016 Advance adv[0] SHALL equal en; adv[i>0] SHALL equal en when CASCADE=0, and adv[i-1] AND (cnt[i-1]==d[i-1]-1) when CASCADE=1, evaluated combinationally on registered state in the same cycle.
REQ-017 On a rising edge with adv[i]=1 and cnt[i]==d[i]-1, the channel SHALL set cnt[i]<=0, tick[i]<=1 and sq[i]<=~sq[i].
REQ-018 On a rising edge with adv[i]=1 and cnt[i]<d[i]-1, the channel SHALL set cnt[i]<=cnt[i]+1 and tick[i]<=0.
REQ-019 On a rising edge with adv[i]=0, cnt[i] and sq[i] SHALL hold and tick[i]<=0; en=0 SHALL never drop or shorten a period.
REQ-020 Tick latency SHALL be one cycle: tick[i] is high in the cycle immediately after the advancing cycle with cnt[i]==d[i]-1; tick period = d[i] advances, sq period = 2*d[i] advances.
REQ-021 If cnt[i]>=d[i] after a load, the channel SHALL treat it as terminal count (wrap to 0 with tick) on the next advance, with no counter overflow.
REQ-022 In CASCADE=1, tick[i] SHALL assert in the same cycle as the tick[i-1] that completes channel i's count.
REQ-023 On ld=1 with ld_ch<NCH, the channel SHALL set div[ld_ch]<=ld_div and cnt[ld_ch]<=0 with tick[ld_ch]<=0, leaving sq[ld_ch] unchanged; other channels SHALL be unaffected.
REQ-024 On ld=1 with ld_ch>=NCH, the load SHALL be ignored with no state change.
REQ-025 On clr=1, every channel SHALL set cnt<=0, tick<=0 and sq<=0 regardless of en, while div registers are retained.
REQ-026 When clr and ld coincide, clr SHALL apply to all channels and the div write SHALL also take effect.
REQ-027 clr and ld SHALL take priority over advance in the same cycle.

Reset
REQ-028 While rst=0, all cnt, tick and sq SHALL be 0 and all div SHALL be DEF_DIV, asynchronously.
REQ-029 On rst deassertion, the first advance SHALL occur on the first rising edge with en=1, and the first tick SHALL follow DEF_DIV advances later.
REQ-030 A reset asserted mid-count SHALL discard any loaded divisor and the count in progress.

Verification
REQ-031 NCH=2, load ch0 div=4, en=1 -> tick[0] high 1 cycle every 4 cycles, sq[0] period 8 cycles.
REQ-032 div=4, drop en for 3 cycles at cnt=2 -> next tick is delayed by exactly 3 cycles.
REQ-033 CASCADE=1, ch0 div=3, ch1 div=2 -> tick[1] every 6 cycles, coincident with every second tick[0].
REQ-034 Load div=0 and div=1 -> tick high every cycle and sq toggling every cycle in both cases; load ld_ch=NCH -> no change.
REQ-035 div=10 at cnt=7, load div=5 -> cnt restarts at 0 and the next tick arrives 5 cycles later; clr at the same time as the load -> sq=0 on all channels.
REQ-036 Assert rst mid-count -> all outputs 0 immediately, and div returns to DEF_DIV (first tick after DEF_DIV cycles).
